uart_to_mem: RTL

Receive-side counterpart of the memory-to-UART record streamer. It accepts bytes from the UART receiver and packs each group of 24 consecutive bytes into one 192-bit record, first byte in the least-significant position. Each completed record is written to the record memory at consecutive addresses starting from 0. After NUM_RECS records it pulses DONE_RECEIVING and releases the memory port.

---
 rtl/uart_mem_pkg.sv | 18 +
 rtl/uart_to_mem_if.sv | 29 ++
 rtl/uart_to_mem_rx_count.sv | 26 ++
 rtl/uart_to_mem.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the record streamers (receive and transmit side).
// Holds the record geometry, default load size, address width, default
// inter-byte timeout and the streamer state encoding.
package uart_mem_pkg;
    localparam int REC_BYTES   = 24;
    localparam int REC_W       = 8 * REC_BYTES;
    localparam int NUM_RECS    = 1000;
    localparam int ADDR_W      = 11;
    localparam int TIMEOUT_CYC = 100000;
    localparam int POS_W       = 5;
    localparam int TO_W        = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2
    } state_e;
endpackage

// File: rtl/uart_to_mem_if.sv
// Bundle of the UART-receive and record-memory signals of uart_to_mem.
//   LOAD_START, UART_VALID, dataFromUART : command/byte side (into the block)
//   dataToMEM, addrToMEM, memWe, memSel  : memory write port (out of the block)
//   FRAME_ERR, DONE_RECEIVING            : status pulses (out of the block)
// Modports: master = whoever feeds bytes and watches the memory port,
//           slave  = the uart_to_mem block itself.
interface uart_to_mem_if;
    import uart_mem_pkg::*;

    logic              LOAD_START;
    logic              UART_VALID;
    logic [7:0]        dataFromUART;
    logic [REC_W-1:0]  dataToMEM;
    logic [ADDR_W-1:0] addrToMEM;
    logic              memWe;
    logic              memSel;
    logic              FRAME_ERR;
    logic              DONE_RECEIVING;

    modport master (
        output LOAD_START, UART_VALID, dataFromUART,
        input  dataToMEM, addrToMEM, memWe, memSel, FRAME_ERR, DONE_RECEIVING
    );

    modport slave (
        input  LOAD_START, UART_VALID, dataFromUART,
        output dataToMEM, addrToMEM, memWe, memSel, FRAME_ERR, DONE_RECEIVING
    );
endinterface

// File: rtl/uart_to_mem_rx_count.sv
// rx_count: WIDTH-bit up-counter with synchronous clear and count enable.
//   clk, srst : clock and synchronous active-high reset
//   clr       : synchronous clear, wins over en
//   en        : increment by one
//   count     : current value
module rx_count #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/uart_to_mem.sv
// uart_to_mem: packs groups of REC_BYTES received UART bytes (first byte in
// the least-significant position) into records and writes them to the record
// memory at addresses 0..NUM_RECS-1, then pulses DONE_RECEIVING and releases
// the memory port. A partial record idle for TIMEOUT_CYC cycles is dropped
// with a FRAME_ERR pulse.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : uart_to_mem_if.slave (byte input, memory port, status)
module uart_to_mem #(
    parameter int NUM_RECS    = uart_mem_pkg::NUM_RECS,
    parameter int TIMEOUT_CYC = uart_mem_pkg::TIMEOUT_CYC
) (
    input  logic          clock,
    input  logic          reset,
    uart_to_mem_if.slave  bus
);
    import uart_mem_pkg::*;

    localparam logic [1:0]        S_IDLE    = IDLE;
    localparam logic [1:0]        S_RECV    = RECV;
    localparam logic [1:0]        S_WRITE   = WRITE;
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(REC_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RECS - 1);
    localparam logic [TO_W-1:0]   LAST_TO   = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_reg, state_next;
    logic [REC_W-1:0]  pack_reg;
    logic [REC_W-1:0]  data_reg;
    logic              ferr_reg;

    logic [POS_W-1:0]  pos;
    logic [ADDR_W-1:0] addr;
    logic [TO_W-1:0]   to_cnt;

    logic byte_in;
    logic last_byte;
    logic timeout;
    logic in_write;
    logic last_rec;

    // Bytes are taken in RECV and also in WRITE, so back-to-back bytes
    // across a record boundary are never lost.
    assign byte_in   = bus.UART_VALID && (state_reg != S_IDLE);
    assign last_byte = byte_in && (state_reg == S_RECV) && (pos == LAST_POS);
    // A byte arriving in the expiry cycle keeps the partial record alive.
    assign timeout   = (state_reg == S_RECV) && (pos != '0) &&
                       (to_cnt == LAST_TO) && !bus.UART_VALID;
    assign in_write  = (state_reg == S_WRITE);
    assign last_rec  = in_write && (addr == LAST_ADDR);

    rx_count #(.WIDTH(POS_W)) u_pos (
        .clk   (clock),
        .srst  (reset),
        .clr   ((state_reg == S_IDLE) || last_byte || timeout),
        .en    (byte_in),
        .count (pos)
    );

    rx_count #(.WIDTH(ADDR_W)) u_addr (
        .clk   (clock),
        .srst  (reset),
        .clr   ((state_reg == S_IDLE) || last_rec),
        .en    (in_write),
        .count (addr)
    );

    // Idle timer only runs while a partial record is pending.
    rx_count #(.WIDTH(TO_W)) u_timeout (
        .clk   (clock),
        .srst  (reset),
        .clr   ((state_reg != S_RECV) || (pos == '0) || bus.UART_VALID || timeout),
        .en    (1'b1),
        .count (to_cnt)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.LOAD_START) state_next = S_RECV;
            S_RECV:  if (last_byte) state_next = S_WRITE;
            S_WRITE: state_next = last_rec ? S_IDLE : S_RECV;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pack_reg  <= '0;
            data_reg  <= '0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ferr_reg  <= timeout;
            if (byte_in) begin
                pack_reg <= {bus.dataFromUART, pack_reg[REC_W-1:8]};
            end else if (timeout) begin
                pack_reg <= '0;
            end
            if (last_byte) begin
                data_reg <= {bus.dataFromUART, pack_reg[REC_W-1:8]};
            end
        end
    end

    assign bus.dataToMEM      = data_reg;
    assign bus.addrToMEM      = addr;
    assign bus.memWe          = in_write;
    assign bus.memSel         = (state_reg != S_IDLE);
    assign bus.FRAME_ERR      = ferr_reg;
    assign bus.DONE_RECEIVING = last_rec;
endmodule
